adc_frame_sequencer: RTL and testbench

ADC_FRAME_SEQUENCER -- requirements
Module: adc_frame_sequencer

---
 rtl/adc_frame_sequencer.sv | 117 +++++++++++
 tb/tb_adc_frame_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_sequencer.sv
// -----------------------------------------------------------------------------
// adc_frame_sequencer
//
// Collects ADC samples into a 64-slot frame. Each slot can average
// 2^AVG_LOG2 consecutive accepted samples (AVG_LOG2 in 0..4). The averaged
// value and its slot index are presented on data/dataChange. These outputs feed
// a downstream register bank that rewrites the selected slot every cycle, so
// both outputs change together on a commit and hold otherwise.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous, active-high reset
//   start        : begin a frame (honoured only in IDLE)
//   continuous   : 1 = restart automatically after slot 63
//   sample       : 11-bit unsigned ADC sample
//   sample_valid : qualifies sample
//   sample_ready : a valid sample is accepted on this edge
//   data         : committed (averaged) slot value
//   dataChange   : committed slot index (register bank select)
//   frame_done   : one-cycle pulse after slot 63 commits
//   busy         : frame in progress
// -----------------------------------------------------------------------------
module adc_frame_sequencer #(
  parameter int unsigned AVG_LOG2 = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic [10:0] sample,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [10:0] data,
  output logic [5:0]  dataChange,
  output logic        frame_done,
  output logic        busy
);

  // The accumulator is wide enough for 2^AVG_LOG2 full-scale samples.
  localparam int unsigned ACC_W = 11 + AVG_LOG2;
  // A zero-width counter is illegal; with AVG_LOG2 = 0 the single bit stays 0.
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [5:0]       idx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             commit;
  logic             last_slot;

  assign busy         = (state == CAPTURE);
  assign sample_ready = busy;
  assign accept       = sample_valid & sample_ready;
  assign commit       = accept & (cnt == CNT_LAST);
  assign last_slot    = commit & (idx == 6'd63);
  assign sum          = acc + ACC_W'(sample);

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CAPTURE;
      CAPTURE: if (last_slot && !continuous) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath. Reset also clears data/dataChange, so the downstream bank sees
  // slot 0 written with 0 while reset is held; that is intended.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      acc        <= '0;
      cnt        <= '0;
      data       <= '0;
      dataChange <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_slot;
      if (state == IDLE) begin
        if (start) begin
          idx <= '0;
          acc <= '0;
          cnt <= '0;
        end
      end else if (commit) begin
        // Truncating average; the slice drops the AVG_LOG2 fraction bits.
        data       <= sum[AVG_LOG2 +: 11];
        dataChange <= idx;
        acc        <= '0;
        cnt        <= '0;
        idx        <= idx + 6'd1;   // wraps 63 -> 0
      end else if (accept) begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_frame_sequencer
//
// Directed bench. Three instances (AVG_LOG2 = 0, 2, 4) share one stimulus;
// each scenario checks the instance it targets and resets all of them before
// the next one. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_adc_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        continuous;
  logic [10:0] sample;
  logic        sample_valid;

  logic        rdy0, rdy2, rdy4;
  logic [10:0] data0, data2, data4;
  logic [5:0]  dc0, dc2, dc4;
  logic        fd0, fd2, fd4;
  logic        busy0, busy2, busy4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adc_frame_sequencer #(.AVG_LOG2(0)) d0 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .sample(sample), .sample_valid(sample_valid), .sample_ready(rdy0),
    .data(data0), .dataChange(dc0), .frame_done(fd0), .busy(busy0));

  adc_frame_sequencer #(.AVG_LOG2(2)) d2 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .sample(sample), .sample_valid(sample_valid), .sample_ready(rdy2),
    .data(data2), .dataChange(dc2), .frame_done(fd2), .busy(busy2));

  adc_frame_sequencer #(.AVG_LOG2(4)) d4 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .sample(sample), .sample_valid(sample_valid), .sample_ready(rdy4),
    .data(data4), .dataChange(dc4), .frame_done(fd4), .busy(busy4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [10:0] s);
    sample_valid = v;
    sample       = s;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    start        = 1'b0;
    continuous   = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    logic [10:0] s;
    int          exp_acc, exp_cnt, exp_data, exp_dc, exp_idx, fd_count;

    // ---------------- reset state ----------------
    do_reset();
    check("rst busy0", busy0, 0);
    check("rst ready0", rdy0, 0);
    check("rst data0", data0, 0);
    check("rst dc0", dc0, 0);
    check("rst fd0", fd0, 0);
    check("rst busy4", busy4, 0);

    // ---------------- pass-through frame, AVG_LOG2 = 0 ----------------
    start = 1'b1;
    step(1'b0, '0);
    start = 1'b0;
    check("A busy after start", busy0, 1);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 11'(i));
      check("A data", data0, i);
      check("A dc", dc0, i);
      if (i < 63) begin
        check("A fd low", fd0, 0);
        check("A busy", busy0, 1);
      end else begin
        check("A fd pulse", fd0, 1);
        check("A busy drop", busy0, 0);
      end
    end
    // start during the frame_done cycle is honoured
    start = 1'b1;
    step(1'b0, '0);
    start = 1'b0;
    check("A fd single", fd0, 0);
    check("A restart busy", busy0, 1);
    check("A data hold", data0, 63);

    // ---------------- averaging by 4 ----------------
    do_reset();
    step(1'b1, 11'd500);             // dropped: IDLE
    step(1'b1, 11'd500);
    start = 1'b1;
    step(1'b1, 11'd500);             // still IDLE on this edge: dropped
    start = 1'b0;
    check("B busy", busy2, 1);
    step(1'b1, 11'd1);
    check("B hold1 data", data2, 0);
    check("B hold1 dc", dc2, 0);
    step(1'b1, 11'd2);
    check("B hold2 data", data2, 0);
    step(1'b0, 11'd999);             // not valid: ignored
    step(1'b1, 11'd3);
    check("B hold3 data", data2, 0);
    step(1'b1, 11'd5);
    check("B commit data", data2, 2);   // 11 >> 2
    check("B commit dc", dc2, 0);
    step(1'b1, 11'd4);
    step(1'b1, 11'd4);
    step(1'b1, 11'd4);
    check("B hold4 data", data2, 2);
    step(1'b1, 11'd7);
    check("B commit2 data", data2, 4);  // 19 >> 2
    check("B commit2 dc", dc2, 1);

    // ---------------- averaging by 16, full scale ----------------
    do_reset();
    start = 1'b1;
    step(1'b0, '0);
    start = 1'b0;
    for (int i = 0; i < 15; i++) step(1'b1, 11'd2047);
    check("C pre data", data4, 0);
    step(1'b1, 11'd2047);
    check("C full data", data4, 2047);
    check("C full dc", dc4, 0);
    for (int i = 0; i < 16; i++) step(1'b1, 11'(i));
    check("C ramp data", data4, 7);     // 120 >> 4
    check("C ramp dc", dc4, 1);

    // ---------------- continuous, two frames ----------------
    do_reset();
    continuous = 1'b1;
    start = 1'b1;
    step(1'b0, '0);
    start = 1'b0;
    fd_count = 0;
    for (int i = 0; i < 128; i++) begin
      s = 11'((i * 7) % 2048);
      step(1'b1, s);
      if (fd0) fd_count++;
      if (i == 63 || i == 127) check("D fd pulse", fd0, 1);
      if (i == 64 || i == 0) check("D fd low", fd0, 0);
      if (i % 16 == 0 || i == 63 || i == 64 || i == 127) begin
        check("D dc", dc0, i % 64);
        check("D data", data0, s);
        check("D busy", busy0, 1);
      end
    end
    step(1'b0, '0);
    check("D fd count", fd_count, 2);
    check("D busy hold", busy0, 1);
    check("D fd clear", fd0, 0);

    // ---------------- reset mid-frame ----------------
    do_reset();
    start = 1'b1;
    step(1'b0, '0);
    start = 1'b0;
    for (int i = 0; i < 40; i++) step(1'b1, 11'(i));
    check("E ten data", data2, 37);     // (36+37+38+39) >> 2
    check("E ten dc", dc2, 9);
    step(1'b1, 11'd100);                // partial sample
    check("E partial hold", data2, 37);
    rst = 1'b1;
    step(1'b1, 11'd5);                  // reset beats acceptance
    check("E rst data2", data2, 0);
    check("E rst dc2", dc2, 0);
    check("E rst busy2", busy2, 0);
    check("E rst ready2", rdy2, 0);
    check("E rst fd2", fd2, 0);
    check("E rst data0", data0, 0);
    check("E rst dc0", dc0, 0);
    rst = 1'b0;
    step(1'b0, '0);
    check("E idle fd", fd2, 0);
    start = 1'b1;
    step(1'b0, '0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 11'd8);
    check("E fresh data", data2, 8);
    check("E fresh dc", dc2, 0);

    // ---------------- sparse valid, start while busy ----------------
    do_reset();
    start = 1'b1;
    step(1'b0, '0);
    start = 1'b0;
    pat = 16'b1011_0110_1101_0011;
    exp_acc = 0; exp_cnt = 0; exp_data = 0; exp_dc = 0; exp_idx = 0;
    for (int k = 0; k < 32; k++) begin
      s = 11'(37 * k + 3);
      start = (k == 5 || k == 17);
      step(pat[k % 16], s);
      if (pat[k % 16]) begin
        exp_acc += int'(s);
        exp_cnt++;
        if (exp_cnt == 4) begin
          exp_data = exp_acc / 4;
          exp_dc   = exp_idx;
          exp_idx++;
          exp_acc  = 0;
          exp_cnt  = 0;
        end
      end
      check("F data", data2, exp_data);
      check("F dc", dc2, exp_dc);
      check("F busy", busy2, 1);
    end
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
